// File: rtl/io_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared defaults, input-mode encodings and the range-overlap
//            helper used by the memory-mapped register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W_DEFAULT   = 32;
  localparam int ADDR_W_DEFAULT   = 5;
  localparam int NUM_IN_DEFAULT   = 4;
  localparam int IN_BASE_DEFAULT  = 1;
  localparam int NUM_OUT_DEFAULT  = 4;
  localparam int OUT_BASE_DEFAULT = 11;

  // Input channel capture modes
  localparam int LEVEL  = 0;
  localparam int STICKY = 1;

  localparam int IN_MODE_DEFAULT = LEVEL;

  // True when [a_base, a_base+a_num) and [b_base, b_base+b_num) share an address
  function automatic bit ranges_overlap(int a_base, int a_num, int b_base, int b_num);
    return (a_base < b_base + b_num) && (b_base < a_base + a_num);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : io_regfile_if
// Purpose  : CPU-side bus of the register file: one write port and two
//            combinational read ports.
// Revision : 1.0 - initial release
// ============================================================================
interface io_regfile_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEFAULT,
  parameter int ADDR_W = regfile_pkg::ADDR_W_DEFAULT
);

  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );

endinterface
`default_nettype wire

// File: rtl/io_regfile_input_capture.sv
`default_nettype none
// ============================================================================
// Module   : input_capture
// Purpose  : One input channel: two-flop synchroniser plus, in sticky mode,
//            edge history, sticky bit and write-1-to-clear logic.
// Revision : 1.0 - initial release
// ============================================================================
module input_capture import regfile_pkg::*; #(
  parameter int IN_MODE = IN_MODE_DEFAULT
) (
  input  wire logic clock,
  input  wire logic ctrl_reset_n,
  input  wire logic async_in,
  input  wire logic clear,
  output logic      value,
  output logic      pending
);

  logic sync_meta;
  logic sync_q;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= async_in;
      sync_q    <= sync_meta;
    end
  end

  if (IN_MODE == STICKY) begin : g_sticky
    // live_* track how long since reset release; hist_live marks that the
    // history flop holds a genuine pin sample rather than a reset value, so
    // a pin held high through reset release is not mistaken for an edge.
    logic live_meta;
    logic live_sync;
    logic hist;
    logic hist_live;
    logic sticky;
    logic rise;

    assign rise = sync_q & ~hist & hist_live;

    // Edge history, validity pipeline and sticky bit (set beats clear)
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
        live_meta <= 1'b0;
        live_sync <= 1'b0;
        hist      <= 1'b0;
        hist_live <= 1'b0;
        sticky    <= 1'b0;
      end else begin
        live_meta <= 1'b1;
        live_sync <= live_meta;
        hist      <= sync_q;
        hist_live <= live_sync;
        if (rise) begin
          sticky <= 1'b1;
        end else if (clear) begin
          sticky <= 1'b0;
        end
      end
    end

    assign value   = sticky;
    assign pending = sticky;
  end else begin : g_level
    logic unused_clear;
    assign unused_clear = clear;
    assign value        = sync_q;
    assign pending      = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/io_regfile.sv
`default_nettype none
// ============================================================================
// Module   : io_regfile
// Purpose  : Two-read/one-write register file with input-mapped channels
//            (level or sticky) and flop-driven output registers.
// Revision : 1.0 - initial release
// ============================================================================
module io_regfile import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int NUM_IN   = NUM_IN_DEFAULT,
  parameter int IN_BASE  = IN_BASE_DEFAULT,
  parameter int NUM_OUT  = NUM_OUT_DEFAULT,
  parameter int OUT_BASE = OUT_BASE_DEFAULT,
  parameter int IN_MODE  = IN_MODE_DEFAULT
) (
  input  wire logic                      clock,
  input  wire logic                      ctrl_reset_n,
  io_regfile_if.slave                    bus,
  input  wire logic [NUM_IN-1:0]         io_in,
  output logic      [NUM_OUT*DATA_W-1:0] io_out,
  output logic                           io_event
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (IN_BASE <= 0 || OUT_BASE <= 0 || NUM_IN < 1 || NUM_OUT < 1 ||
      IN_BASE + NUM_IN > DEPTH || OUT_BASE + NUM_OUT > DEPTH ||
      ranges_overlap(IN_BASE, NUM_IN, OUT_BASE, NUM_OUT) ||
      (IN_MODE != LEVEL && IN_MODE != STICKY)) begin : g_bad_params
    $error("io_regfile: illegal address map or input mode");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_IN-1:0] cap_value;
  logic [NUM_IN-1:0] cap_pending;
  logic [NUM_IN-1:0] cap_clear;
  logic              write_ok;

  function automatic logic is_input(logic [ADDR_W-1:0] a);
    return (int'(a) >= IN_BASE) && (int'(a) < IN_BASE + NUM_IN);
  endfunction

  assign write_ok = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0) &&
                    !is_input(bus.ctrl_writeReg);

  // General and output register storage; input addresses are never stored
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (write_ok) begin
      mem[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign cap_clear[i] = (IN_MODE == STICKY) && bus.ctrl_writeEnable &&
                          (int'(bus.ctrl_writeReg) == IN_BASE + i) &&
                          bus.data_writeReg[0];

    input_capture #(
      .IN_MODE (IN_MODE)
    ) u_cap (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .async_in     (io_in[i]),
      .clear        (cap_clear[i]),
      .value        (cap_value[i]),
      .pending      (cap_pending[i])
    );
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign io_out[j*DATA_W +: DATA_W] = mem[OUT_BASE + j];
  end

  assign io_event = |cap_pending;

  // Stored value, bypassed by a same-cycle write except on input addresses
  function automatic logic [DATA_W-1:0] read_port(logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = mem[a];
    if (bus.ctrl_writeEnable && (bus.ctrl_writeReg == a)) begin
      r = bus.data_writeReg;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(a) == IN_BASE + i) begin
        r    = '0;
        r[0] = cap_value[i];
      end
    end
    if (a == '0) begin
      r = '0;
    end
    return r;
  endfunction

  // Combinational read ports
  always_comb begin
    bus.data_readRegA = read_port(bus.ctrl_readRegA);
    bus.data_readRegB = read_port(bus.ctrl_readRegB);
  end

endmodule
`default_nettype wire

// File: tb/tb_io_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_regfile
// Purpose  : Directed self-checking bench for io_regfile in level and
//            sticky input modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_regfile;
  import regfile_pkg::*;

  logic         clock;
  logic         ctrl_reset_n;
  logic [3:0]   io_in;
  logic [127:0] io_out_l;
  logic [127:0] io_out_s;
  logic         io_event_l;
  logic         io_event_s;

  int n_checks = 0;
  int n_errors = 0;

  io_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_l ();
  io_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_s ();

  io_regfile #(.IN_MODE(LEVEL)) dut_lvl (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus_l),
    .io_in        (io_in),
    .io_out       (io_out_l),
    .io_event     (io_event_l)
  );

  io_regfile #(.IN_MODE(STICKY)) dut_stk (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus_s),
    .io_in        (io_in),
    .io_out       (io_out_s),
    .io_event     (io_event_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    io_in        = 4'b0000;
    bus_l.ctrl_writeEnable = 1'b0; bus_l.ctrl_writeReg = '0; bus_l.data_writeReg = '0;
    bus_l.ctrl_readRegA    = 5'd5; bus_l.ctrl_readRegB = 5'd0;
    bus_s.ctrl_writeEnable = 1'b0; bus_s.ctrl_writeReg = '0; bus_s.data_writeReg = '0;
    bus_s.ctrl_readRegA    = 5'd1; bus_s.ctrl_readRegB = 5'd0;

    // Reset state
    #2;
    check("rst_io_out", io_out_l, 128'h0);
    check("rst_event", {127'h0, io_event_s}, 128'h0);
    check("rst_r5", {96'h0, bus_l.data_readRegA}, 128'h0);
    @(posedge clock); #1;
    ctrl_reset_n = 1'b1;
    repeat (4) tick();

    // Basic write / dual read
    bus_l.ctrl_writeEnable = 1'b1; bus_l.ctrl_writeReg = 5'd5; bus_l.data_writeReg = 32'hDEADBEEF;
    tick();
    bus_l.ctrl_writeEnable = 1'b0; bus_l.ctrl_readRegA = 5'd5; bus_l.ctrl_readRegB = 5'd5;
    #1;
    check("r5_portA", {96'h0, bus_l.data_readRegA}, {96'h0, 32'hDEADBEEF});
    check("r5_portB", {96'h0, bus_l.data_readRegB}, {96'h0, 32'hDEADBEEF});

    // r0 stays zero, even while being written
    bus_l.ctrl_writeEnable = 1'b1; bus_l.ctrl_writeReg = 5'd0; bus_l.data_writeReg = 32'h55;
    bus_l.ctrl_readRegA = 5'd0;
    #1;
    check("r0_during_wr", {96'h0, bus_l.data_readRegA}, 128'h0);
    tick();
    bus_l.ctrl_writeEnable = 1'b0;
    #1;
    check("r0_after_wr", {96'h0, bus_l.data_readRegA}, 128'h0);

    // Write-through bypass
    bus_l.ctrl_readRegA = 5'd7;
    #1;
    check("r7_before", {96'h0, bus_l.data_readRegA}, 128'h0);
    bus_l.ctrl_writeEnable = 1'b1; bus_l.ctrl_writeReg = 5'd7; bus_l.data_writeReg = 32'h1234;
    #1;
    check("r7_bypass", {96'h0, bus_l.data_readRegA}, {96'h0, 32'h1234});
    tick();
    bus_l.ctrl_writeEnable = 1'b0;
    #1;
    check("r7_stored", {96'h0, bus_l.data_readRegA}, {96'h0, 32'h1234});

    // Level input: two-edge latency, writes ignored, no bypass
    bus_l.ctrl_readRegA = 5'd3; bus_l.ctrl_readRegB = 5'd4;
    io_in = 4'b0100;
    tick();
    check("lvl_edge1", {96'h0, bus_l.data_readRegA}, 128'h0);
    tick();
    check("lvl_edge2", {96'h0, bus_l.data_readRegA}, 128'h1);
    check("lvl_other_ch", {96'h0, bus_l.data_readRegB}, 128'h0);
    bus_l.ctrl_writeEnable = 1'b1; bus_l.ctrl_writeReg = 5'd3; bus_l.data_writeReg = 32'hFFFFFFFF;
    #1;
    check("lvl_no_bypass", {96'h0, bus_l.data_readRegA}, 128'h1);
    tick();
    bus_l.ctrl_writeEnable = 1'b0;
    #1;
    check("lvl_wr_ignored", {96'h0, bus_l.data_readRegA}, 128'h1);
    check("lvl_event_zero", {127'h0, io_event_l}, 128'h0);

    // Output register and asynchronous reset
    bus_l.ctrl_writeEnable = 1'b1; bus_l.ctrl_writeReg = 5'd14; bus_l.data_writeReg = 32'hA5;
    #1;
    check("out3_before", {96'h0, io_out_l[127:96]}, 128'h0);
    tick();
    bus_l.ctrl_writeEnable = 1'b0;
    #1;
    check("out3_after", {96'h0, io_out_l[127:96]}, {96'h0, 32'hA5});
    check("out_low_slices", {32'h0, io_out_l[95:0]}, 128'h0);
    #1;
    ctrl_reset_n = 1'b0;
    bus_l.ctrl_readRegA = 5'd5;
    #1;
    check("async_rst_out", io_out_l, 128'h0);
    check("async_rst_r5", {96'h0, bus_l.data_readRegA}, 128'h0);
    #1;
    ctrl_reset_n = 1'b1;
    io_in = 4'b0000;
    repeat (6) tick();

    // Sticky capture: one-cycle pulse, three-edge latency
    bus_s.ctrl_readRegA = 5'd1;
    io_in[0] = 1'b1;
    tick();
    check("stk_edge1", {96'h0, bus_s.data_readRegA}, 128'h0);
    io_in[0] = 1'b0;
    tick();
    check("stk_edge2", {96'h0, bus_s.data_readRegA}, 128'h0);
    tick();
    check("stk_edge3", {96'h0, bus_s.data_readRegA}, 128'h1);
    check("stk_event", {127'h0, io_event_s}, 128'h1);
    repeat (3) tick();
    check("stk_holds", {96'h0, bus_s.data_readRegA}, 128'h1);

    // Write-0 has no effect, write-1 clears
    bus_s.ctrl_writeEnable = 1'b1; bus_s.ctrl_writeReg = 5'd1; bus_s.data_writeReg = 32'hFFFFFFFE;
    tick();
    bus_s.ctrl_writeEnable = 1'b0;
    #1;
    check("stk_wr0_kept", {96'h0, bus_s.data_readRegA}, 128'h1);
    bus_s.ctrl_writeEnable = 1'b1; bus_s.data_writeReg = 32'h1;
    tick();
    bus_s.ctrl_writeEnable = 1'b0;
    #1;
    check("stk_w1c", {96'h0, bus_s.data_readRegA}, 128'h0);
    check("stk_event_clr", {127'h0, io_event_s}, 128'h0);

    // Set coincident with clear: set wins
    io_in[0] = 1'b1;
    tick();
    tick();
    bus_s.ctrl_writeEnable = 1'b1; bus_s.ctrl_writeReg = 5'd1; bus_s.data_writeReg = 32'h1;
    tick();
    bus_s.ctrl_writeEnable = 1'b0;
    #1;
    check("stk_set_wins", {96'h0, bus_s.data_readRegA}, 128'h1);

    // Held-high input does not re-set after a clear
    bus_s.ctrl_writeEnable = 1'b1;
    tick();
    bus_s.ctrl_writeEnable = 1'b0;
    #1;
    check("stk_clr_held", {96'h0, bus_s.data_readRegA}, 128'h0);
    repeat (4) tick();
    check("stk_no_reset", {96'h0, bus_s.data_readRegA}, 128'h0);
    io_in[0] = 1'b0;

    // Input held high through reset release: no spurious set
    io_in[1] = 1'b1;
    repeat (2) tick();
    ctrl_reset_n = 1'b0;
    repeat (2) tick();
    ctrl_reset_n = 1'b1;
    bus_s.ctrl_readRegA = 5'd2;
    repeat (6) tick();
    check("stk_rst_high", {96'h0, bus_s.data_readRegA}, 128'h0);
    check("stk_rst_event", {127'h0, io_event_s}, 128'h0);
    io_in[1] = 1'b0;
    repeat (4) tick();
    io_in[1] = 1'b1;
    repeat (3) tick();
    check("stk_real_edge", {96'h0, bus_s.data_readRegA}, 128'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
